// File: rtl/hazard_scoreboard_unit.sv
// Hazard and forwarding controller for a 5-stage IF/DEC/EX/MEM/WB pipeline.
// It selects the operand forwarding source for each DEC operand.
// It also drives the stall and flush enables: load-use bubbles, memory wait and redirect squash.
// Two saturating counters record the cycles lost to load-use stalls and the redirect flushes.
module hazard_scoreboard_unit #(
  parameter int NUM_SRC  = 2,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_SRC*REG_AW-1:0] dec_rs_addr,
  input  logic [NUM_SRC-1:0]        dec_rs_used,
  input  logic [REG_AW-1:0]         ex_rd_addr,
  input  logic                      ex_reg_write,
  input  logic                      ex_is_load,
  input  logic [REG_AW-1:0]         mem_rd_addr,
  input  logic                      mem_reg_write,
  input  logic [REG_AW-1:0]         wb_rd_addr,
  input  logic                      wb_reg_write,
  input  logic                      ex_redirect,
  input  logic                      mem_req,
  input  logic                      mem_rdy,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      stall_fe,
  output logic                      stall_all,
  output logic                      flush_dec,
  output logic                      flush_ex,
  output logic [CNT_W-1:0]          load_stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt
);

  // The bubble counter only has to hold LOAD_LAT-1, because the first bubble is issued from RUN.
  localparam int BW = (LOAD_LAT > 2) ? $clog2(LOAD_LAT) : 1;

  typedef enum logic {RUN, LSTALL} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   bub_q, bub_d;
  logic [CNT_W-1:0] lcnt_q, lcnt_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;

  logic load_use;
  logic mem_wait;
  logic redirect;
  logic load_stall;

  // Per-operand forwarding select (youngest producer wins) and load-use detection.
  always_comb begin
    logic [REG_AW-1:0] rs;
    logic              chk;
    fwd_sel  = '0;
    load_use = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs  = dec_rs_addr[i*REG_AW +: REG_AW];
      chk = dec_rs_used[i] && (rs != '0);
      if (chk && ex_reg_write && (ex_rd_addr == rs)) begin
        fwd_sel[i*2 +: 2] = 2'b01;
        load_use = load_use | ex_is_load;
      end else if (chk && mem_reg_write && (mem_rd_addr == rs)) begin
        fwd_sel[i*2 +: 2] = 2'b10;
      end else if (chk && wb_reg_write && (wb_rd_addr == rs)) begin
        fwd_sel[i*2 +: 2] = 2'b11;
      end
    end
  end

  // Arbitration: memory wait beats redirect, and redirect beats the load-use stall.
  // A redirect squashes the DEC instruction, so any stall it would need is moot.
  always_comb begin
    mem_wait   = mem_req & ~mem_rdy;
    redirect   = ex_redirect & ~mem_wait;
    load_stall = ~mem_wait & ~redirect & (load_use | (state_q == LSTALL));
  end

  // State register for the load-use bubble FSM.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      bub_q   <= '0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
    end
  end

  // Next state: a memory wait freezes everything, and a redirect cancels pending bubbles.
  always_comb begin
    state_d = state_q;
    bub_d   = bub_q;
    if (mem_wait) begin
      state_d = state_q;
      bub_d   = bub_q;
    end else if (redirect) begin
      state_d = RUN;
      bub_d   = '0;
    end else if (state_q == LSTALL) begin
      bub_d = bub_q - BW'(1);
      if (bub_d == '0) begin
        state_d = RUN;
      end
    end else if (load_use && (LOAD_LAT > 1)) begin
      state_d = LSTALL;
      bub_d   = BW'(LOAD_LAT - 1);
    end
  end

  // Stall and flush enables; all of them are combinational from the current inputs and state.
  always_comb begin
    stall_all = mem_wait;
    stall_fe  = mem_wait | load_stall;
    flush_dec = redirect;
    flush_ex  = redirect | load_stall;
  end

  // Next value of each saturating counter; neither counter advances during a memory wait.
  always_comb begin
    lcnt_d = lcnt_q;
    fcnt_d = fcnt_q;
    if (load_stall && (lcnt_q != '1)) begin
      lcnt_d = lcnt_q + CNT_W'(1);
    end
    if (redirect && (fcnt_q != '1)) begin
      fcnt_d = fcnt_q + CNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lcnt_q <= '0;
      fcnt_q <= '0;
    end else begin
      lcnt_q <= lcnt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign load_stall_cnt = lcnt_q;
  assign flush_cnt      = fcnt_q;

endmodule
